cheri_tsmap_marker: RTL
=======================

CHERI_TSMAP_MARKER -- requirements
Module: cheri_tsmap_marker

Interface
REQ-001 SHALL have parameter HeapBase, default 0, byte address of heap granule 0 (one map bit per 8-byte granule).
REQ-002 SHALL have parameter TSMapSize, default 1024, number of 32-bit map words.
REQ-003 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 req_valid_i  in  1  mark request valid.
REQ-006 req_ready_o  out  1  request accepted in any cycle where req_valid_i & req_ready_o.
REQ-007 req_addr_i  in  32  start byte address of range.
REQ-008 req_len_i  in  32  range length in bytes.
REQ-009 req_set_i  in  1  1 = set map bits (revoke), 0 = clear.
REQ-010 busy_o  out  1  operation in progress.
REQ-011 done_o  out  1  one-cycle completion pulse.
REQ-012 err_o  out  1  qualifies done_o; range rejected.
REQ-013 tsmap_cs_o  out  1  map access request.
REQ-014 tsmap_we_o  out  1  1 = write, 0 = read.
REQ-015 tsmap_addr_o  out  16  map word index.
REQ-016 tsmap_wdata_o  out  32  write data.
REQ-017 tsmap_rdata_i  in  32  read data, valid the cycle after a granted read.
REQ-018 tsmap_gnt_i  in  1  access completes only in a cycle with tsmap_cs_o & tsmap_gnt_i.

Function
REQ-019 SHALL compute, on accept, g0 = (req_addr_i - HeapBase) >> 3 and g1 = (req_addr_i + req_len_i - 1 - HeapBase) >> 3 in 33-bit arithmetic; word index = g[31:5], bit index = g[4:0].
REQ-020 SHALL reject (err_o=1 with done_o, no map access) if req_addr_i < HeapBase, req_addr_i + req_len_i > 2^32, or g1[31:5] >= TSMapSize.
REQ-021 SHALL treat req_len_i = 0 as no-op: done_o=1, err_o=0 the cycle after accept, no map access.
REQ-022 SHALL use states IDLE, RD, MOD, WR, DONE; req_ready_o = 1 only in IDLE; busy_o = 1 in all states except IDLE.
REQ-023 SHALL visit words g0[31:5] to g1[31:5] in ascending order, first access the cycle after accept; per word mask = bits lo..hi (lo = g0[4:0] on first word else 0, hi = g1[4:0] on last word else 31).
REQ-024 Partial-mask word: RD (cs=1, we=0) until granted, then MOD (cs=1, we=1, wdata = set ? rdata|mask : rdata&~mask, rdata captured in the cycle after the read grant and held across stalls).
REQ-025 Full-mask word: handled per REQ-033.
REQ-026 SHALL hold tsmap_addr_o, tsmap_we_o, tsmap_wdata_o stable while tsmap_cs_o=1 and tsmap_gnt_i=0.
REQ-027 After the last word's write grant SHALL enter DONE: done_o=1, err_o=0 for one cycle, then IDLE; tsmap_cs_o=0 in IDLE and DONE.
REQ-028 Request inputs SHALL be ignored while busy_o=1; a new request is accepted the cycle after DONE at the earliest.

Reset
REQ-029 rst_i SHALL force IDLE and req_ready_o=1, busy_o=0, done_o=0, err_o=0, tsmap_cs_o=0, tsmap_we_o=0, tsmap_addr_o=0, tsmap_wdata_o=0.
REQ-030 Reset mid-operation SHALL abort with no done_o; map words already written remain written.

Configuration
REQ-031 Macro CHERI_TSMAP_FULLWORD_WR_EN SHALL select full-word handling.
REQ-032 Without the macro, full-mask words SHALL use RD then MOD like partial words.
REQ-033 With the macro, full-mask words SHALL use WR only: one cycle (until granted), cs=1, we=1, wdata = set ? 32'hFFFF_FFFF : 32'h0, no read.

Structure
REQ-034 State enum and GRANULE_SHIFT=3, WORD_SHIFT=5 SHALL live in cheri_pkg; mask generation SHALL be a sub-module cheri_tsmap_mask (lo, hi in; 32-bit mask out, combinational).

Verification (HeapBase=32'h8000_0000, TSMapSize=1024, gnt=1 unless stated; T = accept cycle)
REQ-035 addr=8000_0000, len=8, set, rdata=0 -> T+1 read word 0, T+2 write 32'h1, T+3 done_o.
REQ-036 addr=8000_0018, len=16, clear, rdata=FFFF_FFFF -> write 32'hFFFF_FFE7 to word 0.
REQ-037 addr=8000_0100, len=32'h300, set -> words 1..3 written FFFF_FFFF; with macro 3 write cycles, done T+4; without, 6 access cycles, done T+7.
REQ-038 addr=7FFF_FFF8, len=8 -> T+1 done_o=1, err_o=1, tsmap_cs_o never asserted; also addr=8004_0000 (word 1024) -> same.
REQ-039 gnt=0 for 3 cycles during MOD -> cs/addr/wdata held; write completes on first granted cycle, done one cycle later.
REQ-040 rst_i asserted in MOD of a 3-word op -> next cycle IDLE, no done_o, req_ready_o=1.

Source files
------------

// File: rtl/cheri_tsmap_marker_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cheri_pkg
//  Purpose  : Shared definitions for the CHERI tag-shadow-map range marker:
//             controller state encoding and granule/word shift amounts.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package cheri_pkg;

   // One map bit per 8-byte granule, 32 granule bits per map word.
   localparam int GRANULE_SHIFT = 3;
   localparam int WORD_SHIFT    = 5;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      MOD  = 3'd2,
      WR   = 3'd3,
      DONE = 3'd4
   } tsmap_state_e;

endpackage
`default_nettype wire

// File: rtl/cheri_tsmap_marker_if.sv
`default_nettype none
// ============================================================================
//  Module   : cheri_tsmap_marker_if
//  Purpose  : Bundles the mark-request handshake, status and tag-map memory
//             port of cheri_tsmap_marker.
//  Ports    : req_*   - mark request (valid/ready, addr, len, set)
//             busy_o, done_o, err_o - status / completion
//             tsmap_* - single-port map memory with grant-based stalls
//             modport slave  : the marker
//             modport master : requester + map memory side
//  Revision : 1.0 - initial release
// ============================================================================
interface cheri_tsmap_marker_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] req_addr_i;
   logic [31:0] req_len_i;
   logic        req_set_i;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic        tsmap_cs_o;
   logic        tsmap_we_o;
   logic [15:0] tsmap_addr_o;
   logic [31:0] tsmap_wdata_o;
   logic [31:0] tsmap_rdata_i;
   logic        tsmap_gnt_i;

   modport slave (
      input  req_valid_i, req_addr_i, req_len_i, req_set_i,
      input  tsmap_rdata_i, tsmap_gnt_i,
      output req_ready_o, busy_o, done_o, err_o,
      output tsmap_cs_o, tsmap_we_o, tsmap_addr_o, tsmap_wdata_o
   );

   modport master (
      output req_valid_i, req_addr_i, req_len_i, req_set_i,
      output tsmap_rdata_i, tsmap_gnt_i,
      input  req_ready_o, busy_o, done_o, err_o,
      input  tsmap_cs_o, tsmap_we_o, tsmap_addr_o, tsmap_wdata_o
   );
endinterface
`default_nettype wire

// File: rtl/cheri_tsmap_marker_mask.sv
`default_nettype none
// ============================================================================
//  Module   : cheri_tsmap_mask
//  Purpose  : Combinational contiguous bit mask, bits i_lo..i_hi set
//             (inclusive, i_lo <= i_hi assumed).
//  Ports    : i_lo   [4:0]  - lowest set bit
//             i_hi   [4:0]  - highest set bit
//             o_mask [31:0] - resulting mask
//  Revision : 1.0 - initial release
// ============================================================================
module cheri_tsmap_mask (
   input  logic [4:0]  i_lo,
   input  logic [4:0]  i_hi,
   output logic [31:0] o_mask
);
   assign o_mask = (32'hFFFF_FFFF << i_lo) & (32'hFFFF_FFFF >> (5'd31 - i_hi));
endmodule
`default_nettype wire

// File: rtl/cheri_tsmap_marker.sv
`default_nettype none
// ============================================================================
//  Module   : cheri_tsmap_marker
//  Purpose  : Sets or clears the tag-shadow-map bits covering a byte range of
//             the heap, one read-modify-write (or plain write) per map word.
//  Ports    : clk_i - clock, rst_i - synchronous active-high reset
//             bus   - cheri_tsmap_marker_if.slave (request, status, map port)
//  Config   : CHERI_TSMAP_FULLWORD_WR_EN - words whose mask covers all 32
//             bits are written directly (no read) when defined.
//  Revision : 1.0 - initial release
// ============================================================================
module cheri_tsmap_marker
   import cheri_pkg::*;
#(
   parameter logic [31:0] HeapBase  = 32'h0,
   parameter int          TSMapSize = 1024
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   cheri_tsmap_marker_if.slave  bus
);

   tsmap_state_e r_state, w_state_nxt, w_next_st;

   logic [26:0] r_word, r_last;
   logic [4:0]  r_lo0, r_hi1;
   logic        r_first, r_set, r_err, r_capture;
   logic [31:0] r_rdata;

   // Range decode in 33-bit arithmetic so borrow/carry stay visible.
   logic [32:0] w_off0, w_end, w_off1, w_g0, w_g1;
   logic [26:0] w_word0, w_word1;
   logic [4:0]  w_lo0, w_hi1, w_lo, w_hi;
   logic        w_noop, w_reject, w_last;
   logic [31:0] w_mask, w_rd_data, w_mod_data;

   logic        w_ready, w_busy, w_done, w_err, w_cs, w_we;
   logic [15:0] w_addr;
   logic [31:0] w_wdata;
   logic        w_accept, w_advance;

   assign w_off0  = {1'b0, bus.req_addr_i} - {1'b0, HeapBase};
   assign w_end   = {1'b0, bus.req_addr_i} + {1'b0, bus.req_len_i};
   assign w_off1  = w_end - 33'd1 - {1'b0, HeapBase};
   assign w_g0    = w_off0 >> GRANULE_SHIFT;
   assign w_g1    = w_off1 >> GRANULE_SHIFT;
   assign w_word0 = 27'(w_g0 >> WORD_SHIFT);
   assign w_word1 = 27'(w_g1 >> WORD_SHIFT);
   assign w_lo0   = w_g0[WORD_SHIFT-1:0];
   assign w_hi1   = w_g1[WORD_SHIFT-1:0];

   // w_off0[32] is the borrow of addr - HeapBase, i.e. addr below the heap.
   assign w_noop   = (bus.req_len_i == 32'd0);
   assign w_reject = w_off0[32] || (w_end > 33'h1_0000_0000) ||
                     ({5'd0, w_word1} >= 32'(TSMapSize));

   // Only the first word starts mid-word, only the last word ends mid-word.
   assign w_last = (r_word == r_last);
   assign w_lo   = r_first ? r_lo0 : 5'd0;
   assign w_hi   = w_last  ? r_hi1 : 5'd31;

   cheri_tsmap_mask u_mask (
      .i_lo   (w_lo),
      .i_hi   (w_hi),
      .o_mask (w_mask)
   );

   // Read data is live in the cycle after the grant, then held in r_rdata
   // so the write data stays stable while the write is stalled.
   assign w_rd_data  = r_capture ? bus.tsmap_rdata_i : r_rdata;
   assign w_mod_data = r_set ? (w_rd_data | w_mask) : (w_rd_data & ~w_mask);

`ifdef CHERI_TSMAP_FULLWORD_WR_EN
   logic w_first_full, w_next_full;
   assign w_first_full = (w_lo0 == 5'd0) && ((w_word0 != w_word1) || (w_hi1 == 5'd31));
   // Any word after the first starts at bit 0; it is full unless it is the
   // last word and the range ends before bit 31.
   assign w_next_full  = ((r_word + 27'd1) != r_last) || (r_hi1 == 5'd31);
   assign w_next_st    = w_next_full ? WR : RD;
`else
   assign w_next_st    = RD;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_busy      = 1'b1;
      w_done      = 1'b0;
      w_err       = 1'b0;
      w_cs        = 1'b0;
      w_we        = 1'b0;
      w_addr      = 16'd0;
      w_wdata     = 32'd0;
      w_accept    = 1'b0;
      w_advance   = 1'b0;
      case (r_state)
         IDLE: begin
            w_ready = 1'b1;
            w_busy  = 1'b0;
            if (bus.req_valid_i) begin
               w_accept = 1'b1;
               if (w_noop || w_reject) begin
                  w_state_nxt = DONE;
               end
`ifdef CHERI_TSMAP_FULLWORD_WR_EN
               else if (w_first_full) begin
                  w_state_nxt = WR;
               end
`endif
               else begin
                  w_state_nxt = RD;
               end
            end
         end
         RD: begin
            w_cs   = 1'b1;
            w_addr = r_word[15:0];
            if (bus.tsmap_gnt_i) begin
               w_state_nxt = MOD;
            end
         end
         MOD, WR: begin
            w_cs    = 1'b1;
            w_we    = 1'b1;
            w_addr  = r_word[15:0];
            w_wdata = (r_state == WR) ? {32{r_set}} : w_mod_data;
            if (bus.tsmap_gnt_i) begin
               if (w_last) begin
                  w_state_nxt = DONE;
               end else begin
                  w_advance   = 1'b1;
                  w_state_nxt = w_next_st;
               end
            end
         end
         DONE: begin
            w_done      = 1'b1;
            w_err       = r_err;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_word    <= 27'd0;
         r_last    <= 27'd0;
         r_lo0     <= 5'd0;
         r_hi1     <= 5'd0;
         r_first   <= 1'b0;
         r_set     <= 1'b0;
         r_err     <= 1'b0;
         r_capture <= 1'b0;
         r_rdata   <= 32'd0;
      end else begin
         r_capture <= (r_state == RD) && bus.tsmap_gnt_i;
         if (r_capture) begin
            r_rdata <= bus.tsmap_rdata_i;
         end
         if (w_accept) begin
            r_word  <= w_word0;
            r_last  <= w_word1;
            r_lo0   <= w_lo0;
            r_hi1   <= w_hi1;
            r_first <= 1'b1;
            r_set   <= bus.req_set_i;
            r_err   <= w_reject && !w_noop;
         end else if (w_advance) begin
            r_word  <= r_word + 27'd1;
            r_first <= 1'b0;
         end
      end
   end

   assign bus.req_ready_o   = w_ready;
   assign bus.busy_o        = w_busy;
   assign bus.done_o        = w_done;
   assign bus.err_o         = w_err;
   assign bus.tsmap_cs_o    = w_cs;
   assign bus.tsmap_we_o    = w_we;
   assign bus.tsmap_addr_o  = w_addr;
   assign bus.tsmap_wdata_o = w_wdata;

endmodule
`default_nettype wire
